// File: rtl/axil_arbiter_2to1.sv
// axil_arbiter_2to1: two AXI4-Lite masters sharing one AXI4-Lite slave.
//
// Only one transaction is outstanding at a time. Arbitration happens in IDLE
// and takes one cycle. If a master presents both a read and a write, the read
// goes first. The grant is then held until the read data or write response
// handshake finishes.
//
// Arbitration policy is selected by the AXIL_ARB_ROUND_ROBIN_EN macro:
//   defined   - round-robin; on a simultaneous request the master that was
//               not granted last wins (master 0 wins first after reset).
//   undefined - fixed priority; master 0 always wins.
//
// Ports
//   clk, resetn           clock, asynchronous active-low reset
//   m_* [1:0]             per-master handshakes, bit i = master i
//   m_awaddr/m_araddr     packed addresses, master i at [i*ADDR_W +: ADDR_W]
//   m_wdata/m_wstrb       packed write data and strobes
//   m_rdata               read data shared by both masters, qualified by m_rvalid[i]
//   s_*                   slave-side AXI4-Lite channels (no resp/prot)
//   grant [1:0]           one-hot owner of the slave, 2'b00 when idle
module axil_arbiter_2to1 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [1:0]              m_awvalid,
  input  logic [1:0]              m_wvalid,
  input  logic [1:0]              m_arvalid,
  input  logic [1:0]              m_bready,
  input  logic [1:0]              m_rready,
  output logic [1:0]              m_awready,
  output logic [1:0]              m_wready,
  output logic [1:0]              m_arready,
  output logic [1:0]              m_bvalid,
  output logic [1:0]              m_rvalid,
  input  logic [2*ADDR_W-1:0]     m_awaddr,
  input  logic [2*ADDR_W-1:0]     m_araddr,
  input  logic [2*DATA_W-1:0]     m_wdata,
  input  logic [2*DATA_W/8-1:0]   m_wstrb,
  output logic [DATA_W-1:0]       m_rdata,
  output logic                    s_awvalid,
  output logic                    s_wvalid,
  output logic                    s_arvalid,
  output logic                    s_bready,
  output logic                    s_rready,
  input  logic                    s_awready,
  input  logic                    s_wready,
  input  logic                    s_arready,
  input  logic                    s_bvalid,
  input  logic                    s_rvalid,
  output logic [ADDR_W-1:0]       s_awaddr,
  output logic [ADDR_W-1:0]       s_araddr,
  output logic [DATA_W-1:0]       s_wdata,
  output logic [DATA_W/8-1:0]     s_wstrb,
  input  logic [DATA_W-1:0]       s_rdata,
  output logic [1:0]              grant
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_e;

  state_e     state_q;
  logic [1:0] grant_q;
  logic       aw_done_q, w_done_q;
  logic       aw_done_d, w_done_d;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
  logic       last_q;  // index of the master granted most recently
`endif

  logic [1:0] req;
  logic       win;  // index of the IDLE-cycle winner
  logic       g;    // index of the granted master (meaningful only when grant_q != 0)

  assign req   = m_arvalid | (m_awvalid & m_wvalid);
  assign g     = grant_q[1];
  assign grant = grant_q;

`ifdef AXIL_ARB_ROUND_ROBIN_EN
  // On a tie, pick the master that was not granted last. Otherwise pick the sole requester.
  assign win = (req == 2'b11) ? ~last_q : req[1];
`else
  assign win = ~req[0];
`endif

  // Payload forwarded from the granted master, zero while idle.
  assign s_awaddr = (grant_q == 2'b00) ? '0 : (g ? m_awaddr[ADDR_W +: ADDR_W] : m_awaddr[0 +: ADDR_W]);
  assign s_araddr = (grant_q == 2'b00) ? '0 : (g ? m_araddr[ADDR_W +: ADDR_W] : m_araddr[0 +: ADDR_W]);
  assign s_wdata  = (grant_q == 2'b00) ? '0 : (g ? m_wdata[DATA_W +: DATA_W] : m_wdata[0 +: DATA_W]);
  assign s_wstrb  = (grant_q == 2'b00) ? '0 :
                    (g ? m_wstrb[DATA_W/8 +: DATA_W/8] : m_wstrb[0 +: DATA_W/8]);
  assign m_rdata  = s_rdata;

  // Handshake routing. Every valid/ready is zero outside the state that owns its channel,
  // so the non-granted master and the IDLE state see all zeros.
  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    m_arready = '0;
    m_bvalid  = '0;
    m_rvalid  = '0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_arvalid = 1'b0;
    s_bready  = 1'b0;
    s_rready  = 1'b0;
    case (state_q)
      RD_ADDR: begin
        s_arvalid    = m_arvalid[g];
        m_arready[g] = s_arready;
      end
      RD_DATA: begin
        m_rvalid[g] = s_rvalid;
        s_rready    = m_rready[g];
      end
      WR_ADDR: begin
        // A channel that has already completed its handshake is masked off, so the
        // slave sees exactly one AW and one W beat.
        s_awvalid    = m_awvalid[g] & ~aw_done_q;
        m_awready[g] = s_awready & ~aw_done_q;
        s_wvalid     = m_wvalid[g] & ~w_done_q;
        m_wready[g]  = s_wready & ~w_done_q;
      end
      WR_RESP: begin
        m_bvalid[g] = s_bvalid;
        s_bready    = m_bready[g];
      end
      default: ;
    endcase
  end

  assign aw_done_d = aw_done_q | (s_awvalid & s_awready);
  assign w_done_d  = w_done_q  | (s_wvalid & s_wready);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
      last_q    <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant_q <= win ? 2'b10 : 2'b01;
            state_q <= m_arvalid[win] ? RD_ADDR : WR_ADDR;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
            last_q  <= win;
`endif
          end
        end
        RD_ADDR: if (s_arvalid && s_arready) state_q <= RD_DATA;
        RD_DATA: begin
          if (s_rvalid && s_rready) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
          end
        end
        WR_ADDR: begin
          if (aw_done_d && w_done_d) begin
            state_q   <= WR_RESP;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
          end
        end
        WR_RESP: begin
          if (s_bvalid && s_bready) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axil_arbiter_2to1.md
AXIL_ARBITER_2TO1 -- requirements
Module: axil_arbiter_2to1

Interface
REQ-001 Parameter ADDR_W, default 32: address width, all channels.
REQ-002 Parameter DATA_W, default 32: data width; strobe width DATA_W/8.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready  input  2 each  per-master handshakes; bit i = master i.
REQ-006 m_awready, m_wready, m_arready, m_bvalid, m_rvalid  output  2 each  per-master handshakes.
REQ-007 m_awaddr, m_araddr  input  2*ADDR_W each  packed addresses; master i at [i*ADDR_W +: ADDR_W].
REQ-008 m_wdata  input  2*DATA_W; m_wstrb  input  2*DATA_W/8  packed write data/strobes.
REQ-009 m_rdata  output  DATA_W  read data, shared by both masters; qualified by m_rvalid[i].
REQ-010 s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready  output  1 each  slave-side handshakes.
REQ-011 s_awready, s_wready, s_arready, s_bvalid, s_rvalid  input  1 each  slave-side handshakes.
REQ-012 s_awaddr, s_araddr  output  ADDR_W; s_wdata  output  DATA_W; s_wstrb  output  DATA_W/8; s_rdata  input  DATA_W.
REQ-013 grant  output  2  one-hot owner of the slave; 2'b00 when idle.

Function
REQ-014 Request of master i = m_arvalid[i] | (m_awvalid[i] & m_wvalid[i]); read wins if a master presents both.
REQ-015 FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP; exactly one transaction outstanding.
REQ-016 IDLE: registers winner into grant, next state RD_ADDR or WR_ADDR; arbitration costs one cycle, no slave valid asserted in IDLE.
REQ-017 RD_ADDR: s_arvalid = m_arvalid[g], s_araddr = granted address, m_arready[g] = s_arready; on AR handshake -> RD_DATA.
REQ-018 RD_DATA: m_rvalid[g] = s_rvalid, s_rready = m_rready[g], m_rdata = s_rdata; on R handshake -> IDLE, grant cleared.
REQ-019 WR_ADDR: AW and W forwarded independently; each channel's completion latched; valid dropped once its handshake is done; when both done -> WR_RESP.
REQ-020 WR_RESP: m_bvalid[g] = s_bvalid, s_bready = m_bready[g]; on B handshake -> IDLE, grant cleared.
REQ-021 Non-granted master: all its ready/valid outputs 0; its requests held without loss until granted.
REQ-022 Granted master dropping valid before handshake is a protocol violation; no recovery required.
REQ-023 Both masters request same cycle in IDLE: resolved per REQ-028.
REQ-024 Unused slave-side payload outputs driven from granted master; 0 when grant == 0.

Reset
REQ-025 resetn low: FSM -> IDLE, grant = 0, AW/W done flags = 0, last-winner pointer = master 1 (so master 0 wins first), all valid/ready outputs 0, asynchronously.
REQ-026 Reset mid-transaction abandons it; after release the slave must itself be reset by the same resetn.

Configuration
REQ-027 Macro AXIL_ARB_ROUND_ROBIN_EN selects arbitration policy.
REQ-028 Defined: round-robin, simultaneous requests go to master not granted last; undefined: fixed priority, master 0 always wins; pointer logic absent.

Verification
REQ-029 Master 0 read 0x0000_0010 alone, slave returns 0xDEAD_BEEF -> grant=01, m_rdata=0xDEAD_BEEF with m_rvalid=01, grant=00 next cycle.
REQ-030 Master 1 write 0x0000_0020 data 0x1234_5678 strb 0xF, W presented 2 cycles after AW -> single s_awvalid/s_wvalid handshakes, m_bvalid=10, memory read back 0x1234_5678.
REQ-031 Both masters read every cycle for 8 transactions, macro defined -> grants alternate 01,10,01,...; undefined -> all 8 grants 01 while master 0 keeps requesting.
REQ-032 Master 0 asserts arvalid and awvalid+wvalid together -> read completes first, write next.
REQ-033 resetn pulsed low during RD_DATA -> grant=00, all m_* valid/ready 0 same cycle; next request served normally.
REQ-034 s_rvalid/s_bvalid stalled by m_rready/m_bready low for 5 cycles -> data held stable, no second grant issued.
